// File: rtl/neuron_pipelined_pkg.sv
// Shared fixed-point formats, activation/FSM enums and the saturate helper
// used by the neuron datapath and future layer blocks.
package neuron_pipelined_pkg;

  localparam int INTEGER_WIDTH  = 8;
  localparam int FRACTION_WIDTH = 8;
  localparam int DATA_WIDTH     = INTEGER_WIDTH + FRACTION_WIDTH;
  localparam int SAT_IN_WIDTH   = 64;

  typedef enum logic [1:0] {LINEAR, RELU, HARD_SIGMOID, HARD_TANH} activation_type_e;
  typedef enum logic [1:0] {IDLE, ACCUMULATE, ACTIVATE, DONE} state_e;

  localparam logic signed [DATA_WIDTH-1:0] DATA_MAX    = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] DATA_MIN    = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] FIX_ONE     = DATA_WIDTH'(1 << FRACTION_WIDTH);
  localparam logic signed [DATA_WIDTH-1:0] FIX_NEG_ONE = -FIX_ONE;
  localparam logic signed [DATA_WIDTH-1:0] FIX_HALF    = DATA_WIDTH'(1 << (FRACTION_WIDTH - 1));

  // Clamp a wide signed value into the DATA_WIDTH signed range.
  function automatic logic signed [DATA_WIDTH-1:0] saturate(
    input logic signed [SAT_IN_WIDTH-1:0] value
  );
    if (value > SAT_IN_WIDTH'(DATA_MAX))
      return DATA_MAX;
    else if (value < SAT_IN_WIDTH'(DATA_MIN))
      return DATA_MIN;
    else
      return value[DATA_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/neuron_pipelined_activation_unit.sv
// Combinational activation: maps a saturated fixed-point sum to the output
// value for the selected activation type.
module activation_unit
  import neuron_pipelined_pkg::*;
#(
  parameter activation_type_e ACTIVATION = RELU
) (
  input  logic signed [DATA_WIDTH-1:0] x,
  output logic signed [DATA_WIDTH-1:0] y
);

  logic signed [DATA_WIDTH:0] sig_pre;

  always_comb begin
    y       = x;
    sig_pre = (DATA_WIDTH+1)'(x >>> 2) + (DATA_WIDTH+1)'(FIX_HALF);
    case (ACTIVATION)
      LINEAR: y = x;
      RELU:   y = x[DATA_WIDTH-1] ? '0 : x;
      HARD_SIGMOID: begin
        // One extra bit keeps x/4 + 0.5 from wrapping before the clamp.
        if (sig_pre[DATA_WIDTH])
          y = '0;
        else if (sig_pre > (DATA_WIDTH+1)'(FIX_ONE))
          y = FIX_ONE;
        else
          y = sig_pre[DATA_WIDTH-1:0];
      end
      HARD_TANH: begin
        if (x > FIX_ONE)
          y = FIX_ONE;
        else if (x < FIX_NEG_ONE)
          y = FIX_NEG_ONE;
        else
          y = x;
      end
      default: y = x;
    endcase
  end

endmodule

// File: rtl/neuron_pipelined.sv
// Fixed-point neuron: act(sum(inputs*weights) + bias), LANES MACs per beat,
// time-multiplexed over ceil(NUM_INPUTS/LANES) beats.
//
// state      | meaning
// IDLE       | waiting for inputs_ready
// ACCUMULATE | one beat of LANES products added per cycle
// ACTIVATE   | rescale, saturate, activate and register into out
// DONE       | output_ready high, out held until inputs_ready drops
module neuron_pipelined
  import neuron_pipelined_pkg::*;
#(
  parameter int               NUM_INPUTS = 120,
  parameter int               LANES      = 4,
  parameter activation_type_e ACTIVATION = RELU
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  inputs_ready,
  input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] inputs,
  input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] weights,
  input  logic [DATA_WIDTH-1:0]                 bias,
  output logic [DATA_WIDTH-1:0]                 out,
  output logic                                  output_ready,
  output logic                                  busy
);

  localparam int N_BEATS    = (NUM_INPUTS + LANES - 1) / LANES;
  localparam int BEAT_W     = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam int PROD_WIDTH = 2 * DATA_WIDTH;
  localparam int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(NUM_INPUTS + 1);

  state_e                        state, state_next;
  logic [BEAT_W-1:0]             beat;
  logic                          last_beat;
  logic signed [ACC_WIDTH-1:0]   acc, beat_sum, acc_shift;
  logic signed [DATA_WIDTH-1:0]  sat_value, act_value;
  logic signed [DATA_WIDTH-1:0]  in_pad [N_BEATS][LANES];
  logic signed [DATA_WIDTH-1:0]  w_pad  [N_BEATS][LANES];

  // Operands past NUM_INPUTS in the last beat are tied to zero.
  for (genvar b = 0; b < N_BEATS; b++) begin : g_beat
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      if (b * LANES + l < NUM_INPUTS) begin : g_real
        assign in_pad[b][l] = inputs[b*LANES+l];
        assign w_pad[b][l]  = weights[b*LANES+l];
      end else begin : g_pad
        assign in_pad[b][l] = '0;
        assign w_pad[b][l]  = '0;
      end
    end
  end

  assign last_beat = (beat == BEAT_W'(N_BEATS - 1));

  always_comb begin
    beat_sum = '0;
    for (int l = 0; l < LANES; l++)
      beat_sum = beat_sum + ACC_WIDTH'(PROD_WIDTH'(in_pad[beat][l] * w_pad[beat][l]));
  end

  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (inputs_ready) state_next = ACCUMULATE;
      ACCUMULATE: if (last_beat) state_next = ACTIVATE;
      ACTIVATE:   state_next = DONE;
      DONE:       if (!inputs_ready) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  assign acc_shift = acc >>> FRACTION_WIDTH;
  assign sat_value = saturate(SAT_IN_WIDTH'(acc_shift));

  activation_unit #(.ACTIVATION(ACTIVATION)) u_activation (
    .x (sat_value),
    .y (act_value)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      acc  <= '0;
      beat <= '0;
      out  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inputs_ready) begin
            acc  <= ACC_WIDTH'($signed(bias)) <<< FRACTION_WIDTH;
            beat <= '0;
          end
        end
        ACCUMULATE: begin
          acc <= acc + beat_sum;
          if (!last_beat) beat <= beat + BEAT_W'(1);
        end
        ACTIVATE: out <= act_value;
        default: ;
      endcase
    end
  end

  assign output_ready = (state == DONE);
  assign busy         = (state == ACCUMULATE) || (state == ACTIVATE);

endmodule
